// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32E instruction fetch sequencer with credit-limited requests and redirect squash
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        invalid
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic          invalid_q;

    logic [31:0]   pcq_mem [BUF_DEPTH];
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;

    logic [31:0]   ib_pc   [BUF_DEPTH];
    logic [31:0]   ib_data [BUF_DEPTH];
    logic [AW-1:0] ib_wr;
    logic [AW-1:0] ib_rd;

    logic [SW-1:0] credit_used;
    logic          req_fire;
    logic          ib_push;
    logic          ib_pop;

    // Stale in-flight requests still hold credit until their responses drain.
    assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = rst_n && !branch_taken && (credit_used < SW'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign ib_push    = imem_resp_valid && (drop_cnt == '0) && !branch_taken;
    assign inst_valid = (buf_count != '0) && !branch_taken;
    assign ib_pop     = inst_valid && inst_ready;
    assign inst_pc    = ib_pc[ib_rd];
    assign inst_data  = ib_data[ib_rd];
    assign invalid    = invalid_q;

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            buf_count   <= '0;
            invalid_q   <= 1'b0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            ib_wr       <= '0;
            ib_rd       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                ib_pc[AW'(i)]   <= '0;
                ib_data[AW'(i)] <= '0;
            end
        end else begin
            invalid_q   <= branch_taken;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (req_fire) begin
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (imem_resp_valid) begin
                pcq_rd <= pcq_rd + AW'(1);
            end
            if (branch_taken) begin
                // A response landing in the redirect cycle is already gone, so it is not counted.
                fetch_pc  <= {branch_addr[31:2], 2'b00};
                drop_cnt  <= outstanding - CW'(imem_resp_valid);
                buf_count <= '0;
                ib_wr     <= '0;
                ib_rd     <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (ib_push) begin
                    ib_pc[ib_wr]   <= pcq_mem[pcq_rd];
                    ib_data[ib_wr] <= imem_resp_data;
                    ib_wr          <= ib_wr + AW'(1);
                end
                if (ib_pop) begin
                    ib_rd <= ib_rd + AW'(1);
                end
                buf_count <= buf_count + CW'(ib_push) - CW'(ib_pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        invalid;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .invalid        (invalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int inv_cnt = 0;
    int inv_last = -1;
    int del_cnt = 0;
    int del_last = -1;
    int gap_cnt = 0;
    int req_cnt = 0;
    int first_req_cyc = -1;
    int first_del_cyc = -1;
    int rd_cyc = 0;
    logic [31:0] first_del_pc = '0;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] req_log[$];
    int          req_cyc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_track();
        del_cnt = 0; del_last = -1; gap_cnt = 0; req_cnt = 0;
        first_req_cyc = -1; first_del_cyc = -1; inv_cnt = 0; inv_last = -1;
        req_log.delete(); req_cyc_log.delete();
    endtask

    // One clock: drive memory response, sample handshakes for the coming edge, advance.
    task automatic cycle();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr_q[0]);
            void'(mem_due_q.pop_front());
            void'(mem_addr_q.pop_front());
        end
        #1;
        if (invalid) begin
            inv_cnt++;
            inv_last = cyc;
        end
        if (branch_taken && rst_n) begin
            check("req blocked on redirect", {31'b0, imem_req_valid}, 32'd0);
            check("inst blocked on redirect", {31'b0, inst_valid}, 32'd0);
            exp_pc_q.delete();
            model_pc = {branch_addr[31:2], 2'b00};
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, model_pc);
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + mem_lat);
            exp_pc_q.push_back(model_pc);
            req_log.push_back(imem_req_addr);
            req_cyc_log.push_back(cyc);
            if (first_req_cyc < 0) first_req_cyc = cyc;
            req_cnt++;
            model_pc = model_pc + 32'd4;
        end
        if (inst_valid && inst_ready) begin
            check("inst expected", {31'b0, exp_pc_q.size() > 0}, 32'd1);
            if (exp_pc_q.size() > 0) begin
                check("inst_pc", inst_pc, exp_pc_q[0]);
                check("inst_data", inst_data, mem_word(exp_pc_q[0]));
                void'(exp_pc_q.pop_front());
            end
            if (del_last >= 0 && cyc != del_last + 1) gap_cnt++;
            if (first_del_cyc < 0) begin
                first_del_cyc = cyc;
                first_del_pc  = inst_pc;
            end
            del_last = cyc;
            del_cnt++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        while ((exp_pc_q.size() > 0 || mem_due_q.size() > 0) && n < 100) begin
            cycle();
            n++;
        end
        check("drain complete", exp_pc_q.size() + mem_due_q.size(), 32'd0);
        run(2);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({pfx, " req_addr"}, imem_req_addr, RESET_PC);
        check({pfx, " inst_valid"}, {31'b0, inst_valid}, 32'd0);
        check({pfx, " inst_data"}, inst_data, 32'd0);
        check({pfx, " inst_pc"}, inst_pc, 32'd0);
        check({pfx, " invalid"}, {31'b0, invalid}, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // Reset release, zero-wait memory, continuous fetch
        rst_n = 1'b1; model_pc = RESET_PC; cyc = 0; mem_lat = 1;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        clear_track();
        run(20);
        check("first req cycle", first_req_cyc, 32'd0);
        check("first inst latency", first_del_cyc - first_req_cyc, 32'd2);
        check("streaming gaps", gap_cnt, 32'd0);
        check("streaming count", del_cnt, 32'd18);
        for (int i = 0; i < 4; i++) check("seq req addr", log_at(i), 32'(4 * i));
        drain();

        // Decode stall: credit exhausted after BUF_DEPTH requests
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        clear_track();
        run(10);
        check("stall req count", req_cnt, 32'd4);
        check("stall req_valid low", {31'b0, imem_req_valid}, 32'd0);
        inst_ready = 1'b1;
        del_cnt = 0; del_last = -1; gap_cnt = 0;
        run(4);
        check("release count", del_cnt, 32'd4);
        check("release gaps", gap_cnt, 32'd0);
        drain();

        // Slow memory, 3 in flight, redirect to 0x100
        mem_lat = 4;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        clear_track();
        run(3);
        check("in flight", req_cnt, 32'd3);
        req_log.delete(); req_cyc_log.delete(); first_del_cyc = -1;
        branch_taken = 1'b1; branch_addr = 32'h100; rd_cyc = cyc;
        cycle();
        branch_taken = 1'b0;
        run(14);
        check("invalid pulses", inv_cnt, 32'd1);
        check("invalid cycle", inv_last, 32'(rd_cyc + 1));
        check("redirect req addr", log_at(0), 32'h100);
        check("redirect req cycle", (req_cyc_log.size() > 0) ? req_cyc_log[0] : -1, 32'(rd_cyc + 1));
        check("first pc after redirect", first_del_pc, 32'h100);
        drain();

        // Redirect coincident with a response while two are outstanding
        mem_lat = 2;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        clear_track();
        run(2);
        imem_req_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h200;
        first_del_cyc = -1; req_log.delete();
        cycle();
        branch_taken = 1'b0; imem_req_ready = 1'b1;
        run(8);
        check("coincident first pc", first_del_pc, 32'h200);
        check("coincident req addr", log_at(0), 32'h200);
        drain();

        // Unaligned target, then back-to-back redirects with address wrap
        mem_lat = 1;
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        clear_track();
        branch_taken = 1'b1; branch_addr = 32'h103;
        cycle();
        branch_taken = 1'b0;
        cycle();
        branch_taken = 1'b1; branch_addr = 32'h40;
        cycle();
        branch_addr = 32'hFFFF_FFFC;
        cycle();
        branch_taken = 1'b0;
        run(6);
        check("aligned target", log_at(0), 32'h100);
        check("wrap target", log_at(1), 32'hFFFF_FFFC);
        check("wrap next", log_at(2), 32'h0);
        check("b2b invalid cycles", inv_cnt, 32'd3);
        drain();

        // Asynchronous reset with a full buffer
        imem_req_ready = 1'b1; inst_ready = 1'b0;
        clear_track();
        run(10);
        check("buffer full before reset", {31'b0, inst_valid}, 32'd1);
        rst_n = 1'b0;
        mem_addr_q.delete(); mem_due_q.delete(); exp_pc_q.delete();
        #1;
        check_reset_outputs("async reset");
        cycle();
        rst_n = 1'b1; model_pc = RESET_PC; inst_ready = 1'b1;
        clear_track();
        run(6);
        check("restart req addr", log_at(0), RESET_PC);
        check("restart first pc", first_del_pc, RESET_PC);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
